hdmi_ddr_serializer: RTL and testbench
======================================

// Module: hdmi_ddr_serializer
// PURPOSE
//  Multi-channel parallel-to-serial DDR output stage for the HDMI TX path.
//  Converts one WIDTH-bit word per channel (e.g. 10-bit TMDS symbol) into a
//  double-data-rate bit stream, 2 bits per clk, on a single fast clock
//  (clk = bit rate / 2, e.g. 5x pixel clock). Replaces per-channel 2:1 ODDR.
//  Adds word framing, bit order, polarity inversion and re-alignment.
// PARAMETERS
//  CHANNELS   4   number of serial lanes (typ. 3 TMDS data + 1 TMDS clock)
//  WIDTH      10  bits per word; must be even and >= 2, else elaboration error
//  LSB_FIRST  1   1: bit 0 of word transmitted first; 0: bit WIDTH-1 first
// PORTS
//  clk      in   1               serial half-rate clock, both edges used at output
//  rst      in   1               asynchronous reset, active-high
//  din      in   CHANNELS*WIDTH  word per lane; lane k = din[k*WIDTH +: WIDTH]
//  din_rdy  out  1               word strobe; din captured at posedge ending this cycle
//  align    in   1               sync pulse; restarts word framing
//  invert   in   CHANNELS        per-lane output polarity invert (static or slow)
//  dout     out  CHANNELS        DDR serial output per lane
// BEHAVIOUR
//  - Reset (async, any time): phase counter cnt=0, shift regs=0, pair regs
//    d0/d1=0, negedge reg d1r=0 (async-cleared too), din_rdy=0, dout=0.
//    Mid-word reset discards the word in flight; no partial bits after release.
//  - cnt counts 0..WIDTH/2-1, wraps to 0. din_rdy = (cnt==WIDTH/2-1) & ~rst,
//    combinational from cnt, so exactly one strobe per WIDTH/2 clks.
//  - At posedge with din_rdy=1: shift reg of every lane loads din (bit-reversed
//    first if LSB_FIRST=0). Otherwise shift reg shifts by 2 toward emitted end.
//  - Each posedge: {d1,d0} <= next 2 bits of shift reg, XORed with invert[k];
//    d0 = earlier bit. Negedge: d1r <= d1. dout = clk ? d1r : d0.
//    => d0 driven in low phase after posedge, d1 in following high phase.
//  - Latency: word loaded at posedge P; first bit on dout from negedge after
//    P+1; last bit ends at posedge P+1+WIDTH/2. Back-to-back words gapless.
//  - align=1 at posedge: cnt <= 0 (takes priority over increment/wrap); next
//    din_rdy comes WIDTH/2-1 clks later. Shift reg keeps shifting (old word
//    truncated, zeros shifted in ^ invert). align coinciding with din_rdy: load
//    still happens, then cnt restarts at 0.
//  - invert applied at pair-register input: takes effect on the next bit pair,
//    never glitches within a half-cycle.
//  - All lanes share cnt; lanes are bit-aligned to each other exactly.
//  - No backpressure: upstream must present valid din whenever din_rdy=1;
//    unconsumed words are simply not sampled.
// TESTING
//  1 CHANNELS=1,WIDTH=10: din=10'h3FF constant -> dout steady 1 after latency;
//    din=10'h000 -> steady 0; din_rdy period exactly 5 clks.
//  2 din=10'h354, LSB_FIRST=1 -> per half-cycle dout 0,0,1,0,1,0,1,0,1,1 from
//    negedge after P+1; LSB_FIRST=0 same word -> 1,1,0,1,0,1,0,1,0,0.
//  3 din=10'h155 every word -> dout toggles every half-cycle, no slip across
//    word boundaries for 100 words; invert=1 -> complemented stream.
//  4 align pulse at cnt=2 -> next din_rdy 4 clks later, then every 5 clks;
//    align on din_rdy cycle -> word loaded, next strobe 4 clks later.
//  5 rst asserted mid-word, asynchronously in clk high and in clk low phase ->
//    dout=0, din_rdy=0 immediately; after release first din_rdy at 5th clk.
//  6 CHANNELS=4, distinct words per lane -> each lane serializes its own word,
//    all lanes' bit boundaries coincident.

Source files
------------

// File: rtl/hdmi_ddr_serializer.sv
// hdmi_ddr_serializer
//   Multi-lane parallel-to-serial DDR output stage for the HDMI TX path.
//   Each lane takes one WIDTH-bit word every WIDTH/2 clocks and emits it two
//   bits per clk: the earlier bit of a pair in the low phase after a posedge,
//   the later bit in the following high phase. It also provides word framing
//   (align), selectable bit order and per-lane polarity inversion.
//
// Ports
//   clk      in   serial half-rate clock; both phases drive dout
//   rst      in   asynchronous reset, active-high
//   din      in   CHANNELS*WIDTH; lane k word = din[k*WIDTH +: WIDTH]
//   din_rdy  out  word strobe; din is captured at the posedge ending this cycle
//   align    in   pulse; restarts word framing at the next posedge
//   invert   in   CHANNELS; per-lane output polarity (applied per bit pair)
//   dout     out  CHANNELS; DDR serial output per lane
module hdmi_ddr_serializer #(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned WIDTH     = 10,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CHANNELS*WIDTH-1:0]    din,
  output logic                         din_rdy,
  input  logic                         align,
  input  logic [CHANNELS-1:0]          invert,
  output logic [CHANNELS-1:0]          dout
);

  localparam int unsigned HALF  = WIDTH / 2;
  localparam int unsigned CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);

  // Odd or sub-2 widths cannot be split into whole bit pairs.
  if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_width_check
    $error("hdmi_ddr_serializer: WIDTH must be even and >= 2");
  end

  // Phase counter, per-lane shift registers and pair registers
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [CHANNELS-1:0][WIDTH-1:0] sr_q, sr_d;
  logic [CHANNELS-1:0]            d0_q, d0_d;
  logic [CHANNELS-1:0]            d1_q, d1_d;
  logic [CHANNELS-1:0]            d1r_q, d1r_d;

  logic                           load_c;
  logic [CHANNELS-1:0][WIDTH-1:0] word_c;

  // Words are stored so that bit 0 of the shift register is always sent first.
  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (LSB_FIRST) begin : g_lsb
        assign word_c[k][i] = din[k*WIDTH + i];
      end else begin : g_msb
        assign word_c[k][i] = din[k*WIDTH + WIDTH - 1 - i];
      end
    end
  end

  assign load_c  = (cnt_q == CNT_LAST);
  assign din_rdy = load_c & ~rst;

  // Next-state: framing counter, load/shift, and pair selection with polarity
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    sr_d  = sr_q;
    d0_d  = d0_q;
    d1_d  = d1_q;
    d1r_d = d1_q;

    // align wins over both increment and wrap
    if (align || load_c) begin
      cnt_d = '0;
    end

    for (int k = 0; k < CHANNELS; k++) begin
      // Pair taken from the current contents before the load/shift below,
      // so the last pair of a word and the first pair of the next are gapless.
      d0_d[k] = sr_q[k][0] ^ invert[k];
      d1_d[k] = sr_q[k][1] ^ invert[k];
      sr_d[k] = load_c ? word_c[k] : (sr_q[k] >> 2);
    end
  end

  // Posedge state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      sr_q  <= '0;
      d0_q  <= '0;
      d1_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
      d0_q  <= d0_d;
      d1_q  <= d1_d;
    end
  end

  // Later bit retimed to negedge so it is stable for the whole high phase
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      d1r_q <= '0;
    end else begin
      d1r_q <= d1r_d;
    end
  end

  // Each mux input is stable while selected: d0 changes only at posedge
  // (high phase shows d1r), d1r changes only at negedge (low phase shows d0).
  assign dout = clk ? d1r_q : d0_q;

endmodule

// File: tb/tb_hdmi_ddr_serializer.sv
// Bench for hdmi_ddr_serializer: a 4-lane LSB-first instance and a 1-lane
// MSB-first instance share clock, reset, align and lane-0 data. A bit-stream
// model predicts every half-cycle of dout and every din_rdy cycle.
module tb_hdmi_ddr_serializer;

  localparam int unsigned CH = 4;
  localparam int unsigned W  = 10;
  localparam int unsigned H  = W / 2;
  localparam int unsigned NL = CH + 1;

  logic          clk    = 1'b0;
  logic          rst    = 1'b0;
  logic [CH*W-1:0] din  = '0;
  logic          align  = 1'b0;
  logic [CH-1:0] invert = '0;
  logic          din_rdy, din_rdy2;
  logic [CH-1:0] dout;
  logic [0:0]    dout2;
  logic [0:0]    invert2;
  logic [NL-1:0] dout_all;

  assign invert2  = invert[0];
  assign dout_all = {dout2, dout};

  always #5 clk = ~clk;

  hdmi_ddr_serializer #(.CHANNELS(CH), .WIDTH(W), .LSB_FIRST(1'b1)) u_dut (
    .clk(clk), .rst(rst), .din(din), .din_rdy(din_rdy),
    .align(align), .invert(invert), .dout(dout)
  );

  hdmi_ddr_serializer #(.CHANNELS(1), .WIDTH(W), .LSB_FIRST(1'b0)) u_dut_msb (
    .clk(clk), .rst(rst), .din(din[W-1:0]), .din_rdy(din_rdy2),
    .align(align), .invert(invert2), .dout(dout2)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Each lane holds the word it is currently sending plus a position in its
  // transmit order; bits past the end of the word are zeros. Every posedge
  // sends the next two bits (polarity from invert at that edge); a word
  // strobe occurs every H clocks counted from reset or the last align.
  logic [W-1:0]  m_word [NL];
  int            m_pos  [NL];
  int            m_since = 0;
  logic [NL-1:0] exp_lo  = '0;
  logic [NL-1:0] exp_hi  = '0;
  logic [NL-1:0] hi_pend = '0;

  function automatic logic [W-1:0] lane_word(input int k);
    logic [CH*W-1:0] d;
    d = din;
    return (k < int'(CH)) ? d[k*W +: W] : d[W-1:0];
  endfunction

  function automatic logic lane_inv(input int k);
    logic [CH-1:0] v;
    v = invert;
    return (k < int'(CH)) ? v[k] : v[0];
  endfunction

  function automatic logic tx_bit(input logic [W-1:0] w, input int i, input bit lsb);
    if (i >= int'(W)) return 1'b0;
    return lsb ? w[i] : w[int'(W) - 1 - i];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_since = 0;
      exp_lo  = '0;
      exp_hi  = '0;
      hi_pend = '0;
      for (int k = 0; k < int'(NL); k++) begin
        m_word[k] = '0;
        m_pos[k]  = int'(W);
      end
    end else begin
      exp_hi = hi_pend;
      for (int k = 0; k < int'(NL); k++) begin
        exp_lo[k]  = tx_bit(m_word[k], m_pos[k],     k < int'(CH)) ^ lane_inv(k);
        hi_pend[k] = tx_bit(m_word[k], m_pos[k] + 1, k < int'(CH)) ^ lane_inv(k);
        if (m_pos[k] < int'(W)) m_pos[k] += 2;
      end
      if (m_since == int'(H) - 1) begin
        for (int k = 0; k < int'(NL); k++) begin
          m_word[k] = lane_word(k);
          m_pos[k]  = 0;
        end
      end
      m_since = (align || (m_since == int'(H) - 1)) ? 0 : m_since + 1;
    end
  end

  // Half-cycle compare of all lanes and the strobes against the model
  always @(clk) begin
    #1;
    if (clk) begin
      check("dout_high_phase", 64'(dout_all), 64'(exp_hi));
    end else begin
      check("dout_low_phase", 64'(dout_all), 64'(exp_lo));
      check("din_rdy", 64'(din_rdy), 64'(!rst && (m_since == int'(H) - 1)));
      check("din_rdy_msb", 64'(din_rdy2), 64'(!rst && (m_since == int'(H) - 1)));
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct packed {
    logic [W-1:0] word;
    logic         inv;
    logic [W-1:0] seq_lsb;  // bit i = i-th transmitted half-cycle
    logic [W-1:0] seq_msb;
  } vec_t;

  vec_t vecs [7];

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_rdy(input string name);
    int g;
    g = 0;
    while (!din_rdy && g < 4*int'(H)) begin
      step();
      g++;
    end
    if (!din_rdy) check(name, 64'(din_rdy), 64'(1));
  endtask

  task automatic count_to_rdy(output int n);
    n = 0;
    while (!din_rdy && n < 4*int'(H)) begin
      step();
      n++;
    end
  endtask

  // Present words at the next strobe and record the 10 half-cycles that follow.
  task automatic capture(input logic [CH*W-1:0] words, input logic [CH-1:0] inv,
                         output logic [NL-1:0][W-1:0] seq);
    seq    = '0;
    din    = words;
    invert = inv;
    wait_rdy("capture_strobe_timeout");
    @(posedge clk);  // word loaded
    @(posedge clk);  // first pair registered
    for (int i = 0; i < int'(H); i++) begin
      @(negedge clk); #1;
      for (int k = 0; k < int'(NL); k++) seq[k][2*i] = dout_all[k];
      @(posedge clk); #1;
      for (int k = 0; k < int'(NL); k++) seq[k][2*i+1] = dout_all[k];
    end
    #1;
  endtask

  task automatic toggle_run(input string name);
    logic [NL-1:0] prev, cur;
    int bad;
    bad = 0;
    @(negedge clk); #1;
    prev = dout_all;
    for (int i = 0; i < 999; i++) begin
      if (i % 2 == 0) @(posedge clk);
      else            @(negedge clk);
      #1;
      cur = dout_all;
      if (cur !== ~prev) bad++;
      prev = cur;
    end
    check(name, 64'(bad), 64'(0));
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [NL-1:0][W-1:0] seq;
    int n;

    vecs[0] = '{word: 10'h3FF, inv: 1'b0, seq_lsb: 10'h3FF, seq_msb: 10'h3FF};
    vecs[1] = '{word: 10'h000, inv: 1'b0, seq_lsb: 10'h000, seq_msb: 10'h000};
    vecs[2] = '{word: 10'h354, inv: 1'b0, seq_lsb: 10'h354, seq_msb: 10'h0AB};
    vecs[3] = '{word: 10'h155, inv: 1'b0, seq_lsb: 10'h155, seq_msb: 10'h2AA};
    vecs[4] = '{word: 10'h155, inv: 1'b1, seq_lsb: 10'h2AA, seq_msb: 10'h155};
    vecs[5] = '{word: 10'h0F0, inv: 1'b0, seq_lsb: 10'h0F0, seq_msb: 10'h03C};
    vecs[6] = '{word: 10'h354, inv: 1'b1, seq_lsb: 10'h0AB, seq_msb: 10'h354};

    // Reset state
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("reset_dout_high", 64'(dout_all), 64'(0));
    check("reset_din_rdy", 64'({din_rdy2, din_rdy}), 64'(0));
    @(negedge clk); #2;
    check("reset_dout_low", 64'(dout_all), 64'(0));
    step();
    rst = 1'b0;

    // First strobe after release and strobe period
    count_to_rdy(n);
    check("first_rdy_after_reset", 64'(n), 64'(4));
    step();
    n = 1;
    while (!din_rdy && n < 4*int'(H)) begin step(); n++; end
    check("rdy_period", 64'(n), 64'(5));

    // Table-driven words (all lanes carry the same word)
    for (int v = 0; v < 7; v++) begin
      capture({CH{vecs[v].word}}, {CH{vecs[v].inv}}, seq);
      check($sformatf("vec%0d_lane0", v), 64'(seq[0]), 64'(vecs[v].seq_lsb));
      check($sformatf("vec%0d_lane3", v), 64'(seq[3]), 64'(vecs[v].seq_lsb));
      check($sformatf("vec%0d_msb", v),   64'(seq[4]), 64'(vecs[v].seq_msb));
    end

    // Distinct words per lane
    capture({10'h155, 10'h3FF, 10'h0F0, 10'h354}, 4'h0, seq);
    check("distinct_lane0", 64'(seq[0]), 64'(10'h354));
    check("distinct_lane1", 64'(seq[1]), 64'(10'h0F0));
    check("distinct_lane2", 64'(seq[2]), 64'(10'h3FF));
    check("distinct_lane3", 64'(seq[3]), 64'(10'h155));
    check("distinct_msb",   64'(seq[4]), 64'(10'h0AB));

    // align at cnt=2
    wait_rdy("align_sync_timeout");
    step(); step(); step();
    align = 1'b1;
    step();
    align = 1'b0;
    count_to_rdy(n);
    check("align_mid_word", 64'(n), 64'(4));
    step();
    n = 1;
    while (!din_rdy && n < 4*int'(H)) begin step(); n++; end
    check("align_then_period", 64'(n), 64'(5));

    // align on the strobe cycle: load still happens, framing restarts
    wait_rdy("align_rdy_timeout");
    din   = {10'h2CB, 10'h111, 10'h3A0, 10'h05F};
    align = 1'b1;
    step();
    align = 1'b0;
    count_to_rdy(n);
    check("align_on_rdy", 64'(n), 64'(4));
    repeat (12) step();

    // Alternating word: continuous toggle across word boundaries, both polarities
    din    = {CH{10'h155}};
    invert = '0;
    repeat (12) step();
    toggle_run("toggle_155");
    invert = '1;
    repeat (12) step();
    toggle_run("toggle_155_inv");
    invert = '0;

    // Reset asserted during the high phase
    din = {CH{10'h3FF}};
    repeat (15) step();
    check("pre_reset_high", 64'(dout_all), 64'(5'h1F));
    #1 rst = 1'b1;
    #1;
    check("reset_high_dout", 64'(dout_all), 64'(0));
    check("reset_high_rdy", 64'({din_rdy2, din_rdy}), 64'(0));
    @(posedge clk); #3;
    rst = 1'b0;
    count_to_rdy(n);
    check("rdy_after_reset_high", 64'(n), 64'(4));

    // Reset asserted during the low phase
    repeat (15) step();
    @(negedge clk); #1;
    check("pre_reset_low", 64'(dout_all), 64'(5'h1F));
    #1 rst = 1'b1;
    #1;
    check("reset_low_dout", 64'(dout_all), 64'(0));
    check("reset_low_rdy", 64'({din_rdy2, din_rdy}), 64'(0));
    @(negedge clk); #2;
    rst = 1'b0;
    count_to_rdy(n);
    check("rdy_after_reset_low", 64'(n), 64'(4));

    // Random words, polarity changes and align pulses
    for (int i = 0; i < 600; i++) begin
      din = {8'($urandom), 32'($urandom)};
      if ($urandom_range(0, 9) == 0) invert = 4'($urandom);
      align = ($urandom_range(0, 15) == 0);
      step();
    end
    align = 1'b0;
    repeat (12) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
